// File: rtl/cell_particle_fetch_pkg.sv
// Shared definitions for the cell particle fetch sequencer.
// Coordinate width, field offsets and FSM state encoding.
package cell_particle_fetch_pkg;

    localparam int COORD_W  = 32;
    localparam int POSX_LSB = 0;
    localparam int POSY_LSB = 32;
    localparam int POSZ_LSB = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Extract one single-float coordinate from a packed {z, y, x} word.
    function automatic logic [COORD_W-1:0] coord_slice(
        input logic [3*COORD_W-1:0] word,
        input int                   lsb
    );
        return word[lsb +: COORD_W];
    endfunction

endpackage

// File: rtl/cell_fetch_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count.
// Overflow and underflow are flagged by simulation assertions.
module cell_fetch_fifo
    import cell_particle_fetch_pkg::*;
#(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);
    localparam logic [IW:0]   CNT_FULL = (IW+1)'(DEPTH);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [IW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic [IW-1:0]    w_rd_nxt;
    logic             w_full;
    logic             w_pop;

    assign w_full   = (r_count == CNT_FULL);
    assign o_empty  = (r_count == '0);
    assign w_pop    = i_pop && !o_empty;
    assign w_rd_nxt = r_rd_idx + IDX_ONE;
    assign o_dout   = r_dout;
    assign o_count  = r_count;

    // Storage array: every push lands at the write index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_idx] <= i_din;
        end
    end

    // Read/write indices and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_idx <= r_wr_idx + IDX_ONE;
            end
            if (w_pop) begin
                r_rd_idx <= w_rd_nxt;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head register: refilled from storage on pop, or straight from
    // the input when the new word becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_pop && (r_count > CNT_ONE)) begin
            r_dout <= r_mem[w_rd_nxt];
        end else if (i_push && (o_empty || (w_pop && r_count == CNT_ONE))) begin
            r_dout <= i_din;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(i_push && w_full && !w_pop)
    ) else $error("cell_fetch_fifo: push into full buffer");

    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(i_pop && o_empty)
    ) else $error("cell_fetch_fifo: pop from empty buffer");

endmodule

// File: rtl/cell_particle_fetch.sv
// Per-cell position read sequencer with credit-limited output buffering.
// Define CELL_FETCH_ZERO_SKIP_EN to drop all-zero (padding) words on return.
module cell_particle_fetch
    import cell_particle_fetch_pkg::*;
#(
    parameter int DATA_WIDTH     = 96,
    parameter int ADDR_WIDTH     = 8,
    parameter int MEM_RD_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_particles,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic [COORD_W-1:0]    out_posx,
    output logic [COORD_W-1:0]    out_posy,
    output logic [COORD_W-1:0]    out_posz
);

    localparam int L   = MEM_RD_LATENCY;
    localparam int FW  = ADDR_WIDTH + DATA_WIDTH;
    localparam int NW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = NW + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [NW-1:0]       CNT_ONE = NW'(1);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_cnt_total;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [L-1:0]          r_sr_vld;
    logic [ADDR_WIDTH-1:0] r_sr_addr [L];

    logic [CW-1:0]         w_inflight;
    logic [NW-1:0]         w_fifo_count;
    logic [FW-1:0]         w_fifo_dout;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_fifo_empty;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drain_ok;

    assign w_credit     = (w_inflight + CW'(w_fifo_count)) < CW'(FIFO_DEPTH);
    assign w_issue      = (r_state == ST_ISSUE) && w_credit;
    assign w_last_issue = (r_rd_ptr == (r_cnt_total - PTR_ONE));
    assign w_pop        = out_valid && out_ready;
    assign w_drain_ok   = (w_inflight == '0) &&
                          (w_fifo_empty || (w_fifo_count == CNT_ONE && w_pop));

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign mem_rden    = w_issue;
    assign mem_address = r_rd_ptr[ADDR_WIDTH-1:0];
    assign mem_wren    = 1'b0;

    // Count reads that are issued but have not yet reached the tap.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < L; i++) begin
            w_inflight = w_inflight + CW'(r_sr_vld[i]);
        end
    end

    // Decide whether the word arriving at the tap enters the buffer.
    always_comb begin
`ifdef CELL_FETCH_ZERO_SKIP_EN
        w_push = r_sr_vld[L-1] && (mem_q != '0);
`else
        w_push = r_sr_vld[L-1];
`endif
    end

    // Delay {rden, address} so it lines up with the returning mem_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr_vld <= '0;
            for (int i = 0; i < L; i++) begin
                r_sr_addr[i] <= '0;
            end
        end else begin
            r_sr_vld[0]  <= w_issue;
            r_sr_addr[0] <= mem_address;
            for (int i = 1; i < L; i++) begin
                r_sr_vld[i]  <= r_sr_vld[i-1];
                r_sr_addr[i] <= r_sr_addr[i-1];
            end
        end
    end

    // Pass sequencing: latch count, walk addresses under credit, drain, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt_total <= '0;
            r_rd_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt_total <= num_particles;
                        r_rd_ptr    <= '0;
                        r_state     <= (num_particles == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + PTR_ONE;
                        if (w_last_issue) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_ok) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    cell_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({r_sr_addr[L-1], mem_q}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid = !w_fifo_empty;
    assign out_id    = w_fifo_dout[FW-1 -: ADDR_WIDTH];
    assign w_word    = w_fifo_dout[DATA_WIDTH-1:0];
    assign out_posx  = coord_slice(w_word[3*COORD_W-1:0], POSX_LSB);
    assign out_posy  = coord_slice(w_word[3*COORD_W-1:0], POSY_LSB);
    assign out_posz  = coord_slice(w_word[3*COORD_W-1:0], POSZ_LSB);

endmodule

// File: tb/tb_cell_particle_fetch.sv
// Testbench for cell_particle_fetch: scoreboard of expected particles
// built from a memory image, checked by a decoupled output monitor.
`timescale 1ns/1ps
module tb_cell_particle_fetch;

    localparam int AW    = 8;
    localparam int DW    = 96;
    localparam int DEPTH = 4;
`ifdef CELL_FETCH_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] id;
        logic [31:0]   z;
        logic [31:0]   y;
        logic [31:0]   x;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_particles = '0;
    logic          busy, done, mem_rden, mem_wren, out_valid;
    logic [AW-1:0] mem_address, out_id;
    logic [DW-1:0] mem_q;
    logic          out_ready = 1'b1;
    logic [31:0]   out_posx, out_posy, out_posz;

    always #5 clk = ~clk;

    cell_particle_fetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_RD_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_particles(num_particles),
        .busy(busy), .done(done), .mem_address(mem_address),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_posx(out_posx), .out_posy(out_posy), .out_posz(out_posz)
    );

    // Cell memory: registered address, registered output (latency 2)
    logic [DW-1:0] mem_data [256];
    logic [AW-1:0] mem_areg = '0;
    logic [DW-1:0] mem_qreg = '0;
    always @(posedge clk) begin
        mem_areg <= mem_address;
        mem_qreg <= mem_data[mem_areg];
    end
    assign mem_q = mem_qreg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Shared between stimulus and monitor
    exp_t sb[$];
    int   t0 = 0;
    int   cur_n = 0;
    int   cur_exp = 0;
    bit   mon_en = 1'b0;
    bit   clr_tog = 1'b0;
    int   ready_mode = 0;

    // Monitor-owned statistics
    bit   clr_seen = 1'b0;
    int   rel, rd_cnt, hs_cnt, valid_cnt, done_cnt, max_out, stab_err;
    int   first_rd, last_rd, first_val, last_hs, done_rel;
    bit   wren_seen, prev_hold;
    exp_t prev_data;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = !((cyc - t0) >= 3 && (cyc - t0) <= 12);
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        int   outst;
        if (clr_tog != clr_seen) begin
            clr_seen = clr_tog;
            rd_cnt = 0; hs_cnt = 0; valid_cnt = 0; done_cnt = 0;
            max_out = 0; stab_err = 0; wren_seen = 1'b0; prev_hold = 1'b0;
            first_rd = -1; last_rd = -1; first_val = -1; last_hs = -1;
            done_rel = -1;
        end
        if (mon_en) begin
            rel = cyc - t0;
            if (mem_wren !== 1'b0) wren_seen = 1'b1;
            if (mem_rden) begin
                chk("rd_addr", {rd_cnt < cur_n, mem_address},
                    {1'b1, AW'(rd_cnt)});
                if (first_rd < 0) first_rd = rel;
                last_rd = rel;
                rd_cnt++;
            end
            act = {out_id, out_posz, out_posy, out_posx};
            if (prev_hold && !(out_valid && act == prev_data)) stab_err++;
            if (out_valid) begin
                valid_cnt++;
                if (first_val < 0) first_val = rel;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_output", hs_cnt, cur_exp - 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_word", act, e);
                end
                hs_cnt++;
                last_hs = rel;
            end
            outst = rd_cnt - hs_cnt;
            if (outst > max_out) max_out = outst;
            prev_hold = out_valid && !out_ready;
            prev_data = act;
            if (done) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
            end
        end
    end

    task automatic fill_mem(int zero_pct);
        for (int a = 0; a < 256; a++) begin
            if ($urandom_range(0, 99) < zero_pct) mem_data[a] = '0;
            else mem_data[a] = {$urandom, $urandom, $urandom | 32'h1};
        end
    endtask

    task automatic launch(int n);
        exp_t e;
        @(posedge clk); #1;
        start = 1'b1;
        num_particles = (AW+1)'(n);
        t0 = cyc;
        cur_n = n;
        clr_tog = ~clr_tog;
        mon_en = 1'b1;
        sb.delete();
        for (int a = 0; a < n; a++) begin
            if (!(SKIP && mem_data[a] == '0)) begin
                e.id = AW'(a);
                e.x  = mem_data[a][31:0];
                e.y  = mem_data[a][63:32];
                e.z  = mem_data[a][95:64];
                sb.push_back(e);
            end
        end
        cur_exp = sb.size();
    endtask

    task automatic wait_done(int n, bit junk, int budget);
        bit seen = 1'b0;
        int r;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            r = cyc - t0;
            start = junk && r >= 1 && r <= n && ($urandom_range(0, 3) == 0);
            num_particles = (AW+1)'($urandom);
        end
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(negedge clk); #1;
        chk("idle_after_done", {busy, done}, 2'b00);
        chk("single_done", done_cnt, 1);
        chk("read_count", rd_cnt, n);
        chk("output_count", hs_cnt, cur_exp);
        chk("sb_drained", sb.size(), 0);
        chk("wren_low", wren_seen, 1'b0);
        chk("stable_stall", stab_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit seen;
        int extra;
        int n;
        bit has_zero;

        fill_mem(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rden", mem_rden, 1'b0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wren", mem_wren, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_id", out_id, 0);
        chk("rst_pos", {out_posz, out_posy, out_posx}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Five particles, ready high
        ready_mode = 0;
        launch(5);
        wait_done(5, 1'b0, 200);
        chk("t5_first_rd", first_rd, 1);
        chk("t5_last_rd", last_rd, 5);
        chk("t5_first_valid", first_val, 4);
        chk("t5_valid_cycles", valid_cnt, 5);
        chk("t5_last_hs", last_hs, 8);
        chk("t5_done", done_rel, 9);

        // Empty cell
        launch(0);
        wait_done(0, 1'b0, 50);
        chk("t0_done", done_rel, 1);
        chk("t0_valid", valid_cnt, 0);

        // Ten particles with downstream stall
        fill_mem(0);
        ready_mode = 1;
        launch(10);
        wait_done(10, 1'b0, 300);
        chk("stall_credit", max_out <= DEPTH, 1'b1);
        chk("stall_done", done_rel, last_hs + 1);

        // Full cell, no address wrap
        ready_mode = 0;
        launch(256);
        wait_done(256, 1'b0, 600);
        chk("full_done", done_rel, 260);
        chk("full_credit", max_out <= DEPTH, 1'b1);

        // Reset after the third output
        launch(10);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (hs_cnt >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("third_output", seen, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_ctl", {busy, done, mem_rden, mem_wren, out_valid}, 5'b0);
        chk("mid_rst_addr", mem_address, 0);
        chk("mid_rst_data", {out_id, out_posz, out_posy, out_posx}, 0);
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (busy || done || mem_rden || out_valid) extra++;
        end
        chk("quiet_after_rst", extra, 0);
        launch(5);
        wait_done(5, 1'b0, 200);
        chk("rerun_done", done_rel, 9);

        // Padding slots at addresses 2 and 4
        fill_mem(0);
        mem_data[2] = '0;
        mem_data[4] = '0;
        launch(6);
        wait_done(6, 1'b0, 200);
        chk("skip_outputs", hs_cnt, SKIP ? 4 : 6);
        chk("skip_done", done_rel, 10);

        // Randomised passes
        for (int p = 0; p < 8; p++) begin
            fill_mem((p % 2 == 0) ? 0 : 15);
            n = $urandom_range(0, 40);
            ready_mode = (p % 3 == 0) ? 0 : 2;
            has_zero = 1'b0;
            for (int a = 0; a < n; a++) begin
                if (mem_data[a] == '0) has_zero = 1'b1;
            end
            launch(n);
            wait_done(n, 1'b1, 3000);
            if (!SKIP || !has_zero) begin
                chk("rand_credit", max_out <= DEPTH, 1'b1);
            end
            if (ready_mode == 0) begin
                chk("rand_done", done_rel, (n == 0) ? 1 : n + 4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cell_particle_fetch.md
# cell_particle_fetch

Read-side sequencer placed directly upstream of a per-cell position memory in the range-limited force pipeline. On a start command it walks that cell's particle addresses and issues reads. It absorbs the fixed memory read latency and splits each returned {posz, posy, posx} word into three 32-bit single-float coordinates. Results go out on a valid/ready stream to the neighbour filter / force evaluation stage, with full backpressure and no lost reads.

## Interface
Parameters:
- DATA_WIDTH, 96, memory word width; {posz, posy, posx}, 32 bits each
- ADDR_WIDTH, 8, cell memory address width
- MEM_RD_LATENCY, 2, cycles from mem_rden/address to valid mem_q; 2 = registered address plus registered output
- FIFO_DEPTH, 4, output buffer entries, power of 2, must be > MEM_RD_LATENCY

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  one-cycle command; sampled only in IDLE
- num_particles  in  ADDR_WIDTH+1  particle count in the cell; range 0..2^ADDR_WIDTH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the pass is complete
- mem_address  out  ADDR_WIDTH  read address to the cell memory
- mem_rden  out  1  read enable
- mem_wren  out  1  held at 0
- mem_q  in  DATA_WIDTH  memory read data
- out_valid  out  1  output word available
- out_ready  in  1  downstream accepts the word
- out_id  out  ADDR_WIDTH  memory address of the output particle
- out_posx, out_posy, out_posz  out  32 each  mem_q[31:0], [63:32], [95:64]

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - on start, latch num_particles into cnt_total and clear the issue counter rd_ptr.
  - If the count is 0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - Drive mem_rden=1 and mem_address=rd_ptr only when credits allow: inflight + fifo_count < FIFO_DEPTH.
  - inflight = number of reads issued but not yet returned.
  - Each issue increments rd_ptr.
  - After issuing address cnt_total-1, go to DRAIN.
- DRAIN: wait until inflight==0 and the FIFO is empty with no handshake pending, then go to DONE.
- DONE: pulse done=1 for exactly one cycle, then go to IDLE.
- Return path:
  - A MEM_RD_LATENCY-deep valid shift register carries {rden, address}.
  - On the tap, push {address, mem_q} into the FIFO.
  - The credit rule guarantees a push never meets a full FIFO; overflow is a design error and asserts in simulation.
- Output: out_valid = FIFO not empty. A pop happens when out_valid && out_ready. Output data must hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop on the same cycle are both performed; fifo_count is unchanged.
- start while busy is ignored. num_particles is ignored except when sampled in IDLE.
- rd_ptr is ADDR_WIDTH+1 bits, so a count of 2^ADDR_WIDTH terminates without address wrap. mem_address = rd_ptr[ADDR_WIDTH-1:0].

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, mem_rden=0, mem_address=0, mem_wren=0.
  - out_valid=0; out_id and out_pos* = 0.
  - FIFO, inflight and the shift register cleared.
- Reset mid-operation: all in-flight reads are discarded. Returning mem_q is ignored after reset because the shift register is cleared. No done pulse.
- Start latency:
  - start sampled at edge 0; first mem_rden high in cycle 1.
  - First out_valid in cycle 2+MEM_RD_LATENCY, i.e. cycle 4 at the default.
- With out_ready held high, throughput is one particle per cycle.
- done is asserted in the cycle after the final output handshake, or in cycle 1 for a zero count.
- busy falls in the cycle after done.

## Configuration
- CELL_FETCH_ZERO_SKIP_EN:
  - Defined: a returned word equal to 96'b0 is an empty or padding slot. It is not pushed into the FIFO, and its credit is released on return.
  - Undefined: every read word is emitted, including zero entries.
- done timing and the read sequence are identical in both builds.

## Structure
- Shared package/define file holds:
  - the 32-bit coordinate width
  - field offsets POSX_LSB=0, POSY_LSB=32, POSZ_LSB=64
  - the FSM state encoding
- One sub-module, cell_fetch_fifo: a synchronous FIFO with registered outputs, count output, and a simulation overflow/underflow assertion.
- Credit logic and the latency shift register stay in the top module.

## Test plan
- num_particles=5, out_ready=1, memory model latency 2:
  - Expect mem_rden at cycles 1-5 with addresses 0-4.
  - out_valid in cycles 4-8 with out_id 0-4 and correct posx/y/z slices.
  - done in cycle 9.
- num_particles=0: no mem_rden; done in cycle 1; out_valid never asserted.
- num_particles=10 with out_ready low for cycles 3-12:
  - No more than 4 reads are outstanding or buffered at once.
  - Output held stable while stalled.
  - All ids 0-9 appear in order, exactly once.
- num_particles=256 with ADDR_WIDTH=8: addresses 0-255 issued once each, no wrap, 256 outputs, then done.
- rst asserted for one cycle after the third output of a 10-particle pass:
  - All outputs at reset values in the next cycle; no done.
  - A new start then runs cleanly from address 0.
- CELL_FETCH_ZERO_SKIP_EN defined, addresses 2 and 4 hold zero, num_particles=6: outputs have ids 0, 1, 3, 5, followed by done.
